// File: rtl/vec_alu_sequencer.sv
// Vector ALU sequencer: per word RF read -> operand capture -> ALU -> RF write.
// Define VEC_ALU_SEQUENCER_TIMEOUT_EN to build in the WAIT-state watchdog.
module vec_alu_sequencer #(
  parameter int WORDS_PER_REG = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_instr,
  input  logic [9:0]  cmd_sew,
  input  logic [3:0]  cmd_vap,
  input  logic [7:0]  cmd_nwords,
  input  logic [4:0]  cmd_vs1,
  input  logic [4:0]  cmd_vs2,
  input  logic [4:0]  cmd_vs3,
  input  logic [4:0]  cmd_vd,
  output logic        rf_ren,
  output logic [9:0]  rf_raddr_a,
  output logic [9:0]  rf_raddr_b,
  output logic [9:0]  rf_raddr_c,
  input  logic [31:0] rf_rdata_a,
  input  logic [31:0] rf_rdata_b,
  input  logic [31:0] rf_rdata_c,
  output logic        rf_wen,
  output logic [9:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        alu_start,
  output logic [7:0]  alu_instr,
  output logic [9:0]  alu_sew,
  output logic [3:0]  alu_vap,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [31:0] alu_opC,
  input  logic        alu_done,
  input  logic [31:0] alu_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int IW = (WORDS_PER_REG > 1) ? $clog2(WORDS_PER_REG) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_ISSUE, S_WAIT, S_WRITE, S_FINISH
  } state_t;

  state_t r_state, w_next;

  logic [IW-1:0] r_idx;
  logic [7:0]    r_cnt;
  logic [7:0]    r_instr;
  logic [9:0]    r_sew;
  logic [3:0]    r_vap;
  logic [4:0]    r_vs1, r_vs2, r_vs3, r_vd;
  logic [31:0]   r_opa, r_opb, r_opc, r_res;

  logic [7:0]    w_cnt;
  logic          w_last;
  logic          w_accept;
  logic [4:0]    w_word;

  assign w_cnt    = (cmd_nwords > 8'(WORDS_PER_REG))
                  ? 8'(WORDS_PER_REG) : cmd_nwords;
  assign w_last   = (8'(r_idx) + 8'd1) >= r_cnt;
  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_word   = 5'(r_idx);

`ifdef VEC_ALU_SEQUENCER_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       w_tmo;

  // r_wdog holds the number of WAIT cycles already spent before this one
  assign w_tmo = (r_wdog == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT) begin
      r_wdog <= r_wdog + 8'd1;
    end else begin
      r_wdog <= '0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    rf_ren    = 1'b0;
    rf_wen    = 1'b0;
    alu_start = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_next = (w_cnt == 8'd0) ? S_FINISH : S_READ;
        end
      end
      S_READ: begin
        rf_ren = 1'b1;
        w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        alu_start = 1'b1;
        if (alu_done) begin
          w_next = S_WRITE;
        end
`ifdef VEC_ALU_SEQUENCER_TIMEOUT_EN
        else if (w_tmo) begin
          err    = 1'b1;
          w_next = S_IDLE;
        end
`endif
      end
      S_WRITE: begin
        rf_wen = 1'b1;
        w_next = w_last ? S_FINISH : S_READ;
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_instr <= '0;
      r_sew   <= '0;
      r_vap   <= '0;
      r_vs1   <= '0;
      r_vs2   <= '0;
      r_vs3   <= '0;
      r_vd    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_opc   <= '0;
      r_res   <= '0;
    end else begin
      if (w_accept) begin
        r_idx   <= '0;
        r_cnt   <= w_cnt;
        r_instr <= cmd_instr;
        r_sew   <= cmd_sew;
        r_vap   <= cmd_vap;
        r_vs1   <= cmd_vs1;
        r_vs2   <= cmd_vs2;
        r_vs3   <= cmd_vs3;
        r_vd    <= cmd_vd;
      end
      if (r_state == S_ISSUE) begin
        r_opa <= rf_rdata_a;
        r_opb <= rf_rdata_b;
        r_opc <= rf_rdata_c;
      end
      if (r_state == S_WAIT && alu_done) begin
        r_res <= alu_out;
      end
      // only advance when another word follows, so idx never wraps
      if (r_state == S_WRITE && !w_last) begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign rf_raddr_a = {r_vs1, w_word};
  assign rf_raddr_b = {r_vs2, w_word};
  assign rf_raddr_c = {r_vs3, w_word};
  assign rf_waddr   = {r_vd, w_word};
  assign rf_wdata   = r_res;
  assign alu_instr  = r_instr;
  assign alu_sew    = r_sew;
  assign alu_vap    = r_vap;
  assign alu_opA    = r_opa;
  assign alu_opB    = r_opb;
  assign alu_opC    = r_opc;

endmodule
